// File: rtl/decoder_pkg.sv
// Shared constants and FSM encoding for the network output decoder.
//   NUM_CLASSES  : width of the one-hot class code
//   INDEX_WIDTH  : width of the binary word index
//   STABLE_COUNT : consecutive matching samples needed to commit
//   CNT_WIDTH    : stability counter width
package decoder_pkg;

    localparam int NUM_CLASSES  = 20;
    localparam int INDEX_WIDTH  = 5;
    localparam int STABLE_COUNT = 4;
    localparam int CNT_WIDTH    = 3;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_COUNTING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_to_index.sv
// Combinational one-hot to binary converter with validity flag.
//   code      : N-bit input, expected one-hot
//   index     : bit position of the set bit (meaningless when !is_onehot)
//   is_onehot : exactly one bit of code is set
module onehot_to_index #(
    parameter int N = 20,
    parameter int W = 5
) (
    input  logic [N-1:0] code,
    output logic [W-1:0] index,
    output logic         is_onehot
);

    logic seen;
    logic multi;

    // OR-ing the positions of all set bits gives the right answer for a
    // one-hot input; multiple set bits are flagged through 'multi'.
    always_comb begin
        index = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (code[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
                index = index | W'(i);
            end
        end
        is_onehot = seen & ~multi;
    end

endmodule

// File: rtl/network_output_decoder.sv
// Debounces the argmax stage's one-hot class code into a committed word index.
//   clk, rst_n            : clock, asynchronous active-low reset
//   sample_en             : strobe, network_encode_output is valid this cycle
//   network_encode_output : one-hot class code
//   word_index/word_valid : committed result, held until word_ready
//   word_ready            : consumer accept
//   code_error            : one-cycle pulse after a non-one-hot sample
//   overrun               : one-cycle pulse after a commit dropped while busy
module network_output_decoder
    import decoder_pkg::*;
#(
    parameter int NUM_CLASSES  = decoder_pkg::NUM_CLASSES,
    parameter int INDEX_WIDTH  = decoder_pkg::INDEX_WIDTH,
    parameter int STABLE_COUNT = decoder_pkg::STABLE_COUNT,
    parameter int CNT_WIDTH    = decoder_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_en,
    input  logic [NUM_CLASSES-1:0] network_encode_output,
    output logic [INDEX_WIDTH-1:0] word_index,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   code_error,
    output logic                   overrun
);

    localparam logic [CNT_WIDTH-1:0] STABLE = CNT_WIDTH'(STABLE_COUNT);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    logic [INDEX_WIDTH-1:0] dec_index;
    logic                   dec_onehot;

    state_t                 state, state_n;
    logic [INDEX_WIDTH-1:0] cand, cand_n;
    logic [CNT_WIDTH-1:0]   cnt, cnt_n;
    logic                   commit;
    logic                   restart;
    logic                   err_n;

    onehot_to_index #(
        .N (NUM_CLASSES),
        .W (INDEX_WIDTH)
    ) u_dec (
        .code      (network_encode_output),
        .index     (dec_index),
        .is_onehot (dec_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        commit  = 1'b0;
        restart = 1'b0;
        err_n   = 1'b0;
        if (sample_en) begin
            if (!dec_onehot) begin
                // Clearing the lock lets the same word commit again later.
                err_n   = 1'b1;
                state_n = ST_EMPTY;
                cnt_n   = '0;
            end else begin
                case (state)
                    ST_COUNTING: begin
                        if (dec_index == cand) begin
                            if (cnt < STABLE) cnt_n = cnt + ONE;
                            if (cnt + ONE >= STABLE) begin
                                commit  = 1'b1;
                                state_n = ST_LOCKED;
                            end
                        end else begin
                            restart = 1'b1;
                        end
                    end
                    // Repeats of the locked word are ignored.
                    ST_LOCKED: restart = (dec_index != cand);
                    default:   restart = 1'b1;
                endcase
                if (restart) begin
                    cand_n = dec_index;
                    cnt_n  = ONE;
                    if (STABLE_COUNT == 1) begin
                        commit  = 1'b1;
                        state_n = ST_LOCKED;
                    end else begin
                        state_n = ST_COUNTING;
                    end
                end
            end
        end
    end

    // A commit can land in the same cycle the pending word is accepted;
    // otherwise a commit against a pending word is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_index <= '0;
            word_valid <= 1'b0;
            code_error <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            code_error <= err_n;
            overrun    <= 1'b0;
            if (commit) begin
                if (!word_valid || word_ready) begin
                    word_index <= cand_n;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_network_output_decoder.sv
module tb_network_output_decoder;
    import decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [19:0] code;
    logic [4:0]  word_index;
    logic        word_valid;
    logic        word_ready;
    logic        code_error;
    logic        overrun;

    int checks = 0;
    int fails  = 0;
    logic [4:0] exp_q[$];
    logic       seen = 1'b0;

    network_output_decoder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sample_en             (sample_en),
        .network_encode_output (code),
        .word_index            (word_index),
        .word_valid            (word_valid),
        .word_ready            (word_ready),
        .code_error            (code_error),
        .overrun               (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each newly presented word is popped and compared once;
    // a word is re-armed after a handshake that the next edge will take.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (word_valid && !seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got word_index=%0d, expected no commit", word_index);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    if (word_index !== e) begin
                        fails++;
                        $display("FAIL sb_index: got %0d, expected %0d", word_index, e);
                    end
                end
                seen = 1'b1;
            end
            if (word_valid && word_ready) seen = 1'b0;
        end
    end

    // Inputs change 2 time units after the rising edge; outputs are checked there too.
    task automatic strobe(input logic [19:0] c, input int n);
        @(posedge clk); #2;
        sample_en = 1'b1;
        code      = c;
        repeat (n) @(posedge clk);
        #2;
        sample_en = 1'b0;
        code      = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_en = 1'b0; code = '0; word_ready = 1'b1;
        #12;
        checks++;
        if ({word_valid, word_index, code_error, overrun} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b i=%0d e=%b o=%b, expected all 0",
                     word_valid, word_index, code_error, overrun);
        end
        checks++;
        if (dut.state !== ST_EMPTY) begin
            fails++;
            $display("FAIL reset_state: got %0d, expected %0d", dut.state, ST_EMPTY);
        end
        @(posedge clk); #2; rst_n = 1'b1;
    endtask

    task automatic test_stable_commit();
        word_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            strobe(20'h00008, 1);
            chk("stable_no_early", word_valid, 0);
        end
        exp_q.push_back(5'd3);
        strobe(20'h00008, 1);
        chk("stable_valid", word_valid, 1);
        chk("stable_index", word_index, 3);
        idle(1);
        chk("stable_one_cycle", word_valid, 0);
        strobe(20'h00008, 1);
        chk("stable_no_recommit", word_valid, 0);
    endtask

    task automatic test_candidate_switch();
        word_ready = 1'b1;
        strobe(20'h00001, 1);
        strobe(20'h00001, 1);
        for (int k = 0; k < 3; k++) begin
            strobe(20'h00002, 1);
            chk("switch_no_commit", word_valid, 0);
        end
        exp_q.push_back(5'd1);
        strobe(20'h00002, 1);
        chk("switch_valid", word_valid, 1);
        chk("switch_index", word_index, 1);
        idle(1);
    endtask

    task automatic test_code_error();
        word_ready = 1'b1;
        strobe(20'h00000, 1);
        chk("err_zero_pulse", code_error, 1);
        chk("err_zero_valid", word_valid, 0);
        idle(1);
        chk("err_pulse_width", code_error, 0);
        strobe(20'h00011, 1);
        chk("err_multi_pulse", code_error, 1);
        chk("err_state_empty", dut.state, ST_EMPTY);
        chk("err_multi_valid", word_valid, 0);
        idle(1);
    endtask

    task automatic test_overrun();
        word_ready = 1'b0;
        exp_q.push_back(5'd5);
        strobe(20'h00020, 4);
        chk("ovr_first_valid", word_valid, 1);
        chk("ovr_first_index", word_index, 5);
        strobe(20'h80000, 4);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_index_held", word_index, 5);
        chk("ovr_valid_held", word_valid, 1);
        idle(1);
        chk("ovr_pulse_width", overrun, 0);
        word_ready = 1'b1;
        idle(1);
        chk("ovr_accept_drop", word_valid, 0);
    endtask

    task automatic test_recommit();
        word_ready = 1'b1;
        exp_q.push_back(5'd7);
        strobe(20'h00080, 4);
        chk("recommit_first", word_index, 7);
        idle(1);
        strobe(20'h00000, 1);
        chk("recommit_err", code_error, 1);
        exp_q.push_back(5'd7);
        strobe(20'h00080, 4);
        chk("recommit_valid", word_valid, 1);
        chk("recommit_index", word_index, 7);
        idle(1);
    endtask

    task automatic test_back_to_back();
        // Accept and commit in the same cycle: new word replaces old, no overrun.
        word_ready = 1'b0;
        exp_q.push_back(5'd2);
        strobe(20'h00004, 4);
        chk("b2b_first", word_index, 2);
        @(posedge clk); #2;
        sample_en = 1'b1; code = 20'h00010;
        repeat (3) @(posedge clk);
        #2;
        word_ready = 1'b1;
        exp_q.push_back(5'd4);
        @(posedge clk); #2;
        sample_en = 1'b0; code = '0;
        chk("b2b_valid", word_valid, 1);
        chk("b2b_index", word_index, 4);
        chk("b2b_no_overrun", overrun, 0);
        idle(1);
        chk("b2b_drop", word_valid, 0);
    endtask

    task automatic test_reset_mid();
        word_ready = 1'b1;
        strobe(20'h00040, 2);
        #1; rst_n = 1'b0; #1;
        chk("rst_mid_outputs", {word_valid, word_index, code_error, overrun}, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        strobe(20'h00040, 3);
        chk("rst_mid_no_commit", word_valid, 0);
        idle(1);
        // Reset with a word pending: the word is lost.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        word_ready = 1'b0;
        exp_q.push_back(5'd6);
        strobe(20'h00040, 4);
        chk("rst_pend_valid", word_valid, 1);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk("rst_pend_outputs", {word_valid, word_index, code_error, overrun}, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        strobe(20'h00040, 3);
        chk("rst_pend_no_commit", word_valid, 0);
        word_ready = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_stable_commit();
        test_candidate_switch();
        test_code_error();
        test_overrun();
        test_recommit();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d unseen commits, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/network_output_decoder.md
# network_output_decoder

Consumes the 20-bit one-hot class code produced by the network's argmax stage and turns it into a committed binary word index for the downstream display/control logic. Each sampled code is checked for one-hot validity, converted to an index, and debounced: a class must win on STABLE_COUNT consecutive samples before it is committed. Committed results are presented through a valid/ready handshake.

## Interface
- NUM_CLASSES, 20, width of the one-hot code; one bit per recognisable word
- INDEX_WIDTH, 5, width of the binary index; must satisfy 2^INDEX_WIDTH >= NUM_CLASSES
- STABLE_COUNT, 4, consecutive identical valid samples required to commit; range 1..7
- CNT_WIDTH, 3, stability counter width; must hold STABLE_COUNT
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- sample_en  input  1  one-cycle strobe: network_encode_output holds a new code this cycle
- network_encode_output  input  NUM_CLASSES  one-hot code; bit k means class k won
- word_index  output  INDEX_WIDTH  committed class index, 0..NUM_CLASSES-1
- word_valid  output  1  word_index holds an unconsumed result
- word_ready  input  1  consumer accepts word_index when word_valid && word_ready
- code_error  output  1  one-cycle pulse: the sampled code was not one-hot
- overrun  output  1  one-cycle pulse: a commit was dropped because the output was still pending

## Operation
- Decode only on cycles with sample_en=1. All other cycles hold state; word_ready is still honoured.
- Decode rule: exactly one bit set gives a valid sample, index = bit position (bit 0 -> 0, bit 19 -> 19). Zero bits or two or more bits set gives an invalid sample.
- FSM states:
  - EMPTY: no candidate.
  - COUNTING: candidate held, count < STABLE_COUNT.
  - LOCKED: candidate committed.
- Invalid sample, any state: pulse code_error, go to EMPTY, count=0. The lock is cleared, so the same word can be committed again after a gap.
- Valid sample in EMPTY: candidate=index, count=1. If STABLE_COUNT=1, commit and go to LOCKED; otherwise go to COUNTING.
- Valid sample in COUNTING:
  - Same index as candidate: count+1. On reaching STABLE_COUNT, commit and go to LOCKED.
  - Different index: candidate=index, count=1, stay in COUNTING.
- Valid sample in LOCKED:
  - Same index: no action, no re-commit.
  - Different index: candidate=index, count=1, go to COUNTING (or commit immediately if STABLE_COUNT=1).
- Commit behaviour:
  - If word_valid=0, or word_ready=1 in the same cycle: word_index<=candidate, word_valid<=1.
  - Otherwise: word_index is retained, the new result is dropped, overrun pulses. The FSM still enters LOCKED.
- Handshake: word_valid=1 deasserts on the edge after word_valid && word_ready, unless a commit occurs in that same cycle. word_index is stable while word_valid=1 and not accepted.

## Timing
- Reset values: word_index=0, word_valid=0, code_error=0, overrun=0, FSM=EMPTY, count=0, candidate=0.
- Latency: the Nth matching sample strobed at edge t gives word_valid=1 and the new word_index after edge t, i.e. visible in the next cycle. code_error and overrun are registered, high for exactly the one cycle after the causing sample.
- Back-to-back sample_en on every cycle is supported; there is no throughput limit.
- Reset mid-count or with word_valid pending: everything returns to the reset values immediately (asynchronous), and the pending word is lost.
- The count saturates at STABLE_COUNT and never wraps.

## Structure
- Shared package decoder_pkg holds NUM_CLASSES, INDEX_WIDTH, and the FSM state encoding (EMPTY=2'd0, COUNTING=2'd1, LOCKED=2'd2).
- One combinational sub-module, onehot_to_index: input NUM_CLASSES bits; outputs index and is_onehot. Reusable elsewhere in the design.
- The top level holds the FSM, candidate/count registers, the output register and the pulse flags.

## Test plan
- Four strobes of 20'h00008, word_ready=1 -> word_valid high for one cycle after the 4th strobe, word_index=3; a 5th identical strobe gives no new commit.
- Strobes 20'h00001, 20'h00001, 20'h00002, then 20'h00002 x4 -> only commit is word_index=1, after the 6th strobe.
- Strobe 20'h00000, then 20'h00011 -> code_error pulses once per strobe, FSM stays EMPTY, word_valid stays 0.
- Commit index 5 with word_ready=0, then 4 strobes of 20'h80000 -> overrun pulse, word_index stays 5; assert ready -> word_valid drops next cycle.
- Commit 7, then invalid strobe, then 4 strobes of 20'h00080 -> second commit of index 7 occurs.
- Drop rst_n mid-count and again with word_valid=1 -> all outputs 0 immediately; three further matching strobes after release do not commit.
